func_sweep_checker: RTL and testbench
=====================================

// Module: func_sweep_checker
// PURPOSE
//  Sequential stimulus/response stage wrapped around the 4-input combinational function block f(A,B,C,D).
//  Upstream role: on request, drives A,B,C,D through all 16 codes 0..15 (A = MSB).
//  Downstream role: after a programmable settle time, samples f and builds a 16-bit truth table.
//  Compares the table against an expected minterm mask and reports pass/fail with a start/busy/done handshake.
// PARAMETERS
//  SETTLE_CYCLES  2        cycles each code is held before f is sampled; legal range 1..15
//  EXPECT_TT      16'h87B6 expected truth table, bit i = f at code i (minterms 1,2,4,5,7,8,9,10,15)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous reset, active-high
//  start      in   1   sweep request, sampled only in IDLE
//  f_in       in   1   output f of the function block under test
//  a,b,c,d    out  1   stimulus to the function block; {a,b,c,d} = current code
//  busy       out  1   high from start acceptance until done
//  done       out  1   one-cycle pulse: sweep complete, results valid
//  truth_tbl  out  16  captured f values, bit i = f at code i
//  pass       out  1   truth_tbl == EXPECT_TT; valid from done until next accepted start
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; a=b=c=d=0; busy=0; done=0; truth_tbl=0; pass=0; code=0; settle counter=0.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  IDLE:
//   - start=1 at an edge -> SETTLE.
//   - On that edge: code=0, cnt=SETTLE_CYCLES-1, busy=1, truth_tbl=0, pass=0.
//  SETTLE:
//   - {a,b,c,d}=code is held.
//   - cnt!=0 -> cnt--.
//   - cnt==0 -> SAMPLE.
//   - Occupies exactly SETTLE_CYCLES cycles.
//  SAMPLE (1 cycle):
//   - At the exit edge, truth_tbl[code] <= f_in.
//   - code<15 -> code++, cnt=SETTLE_CYCLES-1, -> SETTLE.
//   - code==15 -> DONE; code holds at 15 (no wrap to 0).
//  DONE (1 cycle):
//   - done=1, busy=0, pass=(truth_tbl==EXPECT_TT).
//   - Next edge -> IDLE, done=0.
//  Timing:
//   - Each code costs SETTLE_CYCLES+1 cycles.
//   - done is high during the cycle that begins 16*(SETTLE_CYCLES+1) edges after the start-accepting edge.
//   - Default: 48 edges.
//  Output holding: a,b,c,d keep the last code (15) in DONE and IDLE until the next start; truth_tbl and pass hold likewise.
//  start while busy or in DONE: ignored, no queuing. start held high continuously: a new sweep begins on the first IDLE edge after DONE.
//  f_in is sampled only at SAMPLE exit edges; glitches during SETTLE have no effect.
//  Reset mid-sweep: immediate abort to reset values; no done pulse; partial table discarded.
// CONFIGURATION
//  Macro FUNC_SWEEP_ERRLOG_EN.
//  Defined:
//   - Adds outputs err_valid (1) and first_err_idx (4).
//   - Both are cleared at reset and at start acceptance.
//   - At the first SAMPLE where f_in != EXPECT_TT[code], err_valid=1 and first_err_idx=code; later mismatches do not overwrite.
//   - Both hold until the next start.
//  Not defined: ports absent; all other behaviour identical.
// TESTING
//  1. Correct DUT, default params, start pulse at edge 0
//     -> busy high at edges 1..48, done one cycle after edge 48, truth_tbl=16'h87B6, pass=1.
//  2. f_in tied 0 -> truth_tbl=16'h0000, pass=0.
//     With ERRLOG: err_valid=1, first_err_idx=4'd1.
//  3. Correct DUT but f forced 1 at code 3 only -> truth_tbl=16'h87BE, pass=0.
//     With ERRLOG: first_err_idx=4'd3.
//  4. start pulsed at the 10th busy cycle and in DONE
//     -> no restart; exactly one done pulse, 48 cycles after the first start.
//  5. rst asserted asynchronously mid-sweep at code 7 -> outputs zero immediately, no done.
//     start afterwards -> clean full sweep, pass=1.
//  6. SETTLE_CYCLES=1 -> done after 32 edges.
//     Track {a,b,c,d} 0..15 on each SAMPLE; it must step by exactly 1 every 2 cycles.

Source files
------------

// File: rtl/func_sweep_checker.sv
// Drives the 16 input codes of a 4-input function block, samples f after a settle time,
// builds its truth table and compares it with EXPECT_TT. Optional error log: FUNC_SWEEP_ERRLOG_EN.
module func_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECT_TT     = 16'h87B6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_tbl,
  output logic        pass
`ifdef FUNC_SWEEP_ERRLOG_EN
  ,
  output logic        err_valid,
  output logic [3:0]  first_err_idx
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] tbl_q, tbl_d;
  logic        pass_q, pass_d;
  logic        errv_q, errv_d;
  logic [3:0]  eidx_q, eidx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tbl_q   <= '0;
      pass_q  <= 1'b0;
      errv_q  <= 1'b0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tbl_q   <= tbl_d;
      pass_q  <= pass_d;
      errv_q  <= errv_d;
      eidx_q  <= eidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    tbl_d   = tbl_q;
    pass_d  = pass_q;
    errv_d  = errv_q;
    eidx_d  = eidx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          code_d  = '0;
          cnt_d   = CNT_RELOAD;
          busy_d  = 1'b1;
          tbl_d   = '0;
          pass_d  = 1'b0;
          errv_d  = 1'b0;
          eidx_d  = '0;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = SAMPLE;
      end
      SAMPLE: begin
        tbl_d[code_q] = f_in;
        // Only the first mismatching code is logged.
        if (!errv_q && (f_in != EXPECT_TT[code_q])) begin
          errv_d = 1'b1;
          eidx_d = code_q;
        end
        if (code_q != 4'd15) begin
          code_d  = code_q + 4'd1;
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end else begin
          // Code stays at 15 so the stimulus holds the last vector.
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (tbl_d == EXPECT_TT);
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign {a, b, c, d} = code_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign truth_tbl    = tbl_q;
  assign pass         = pass_q;
`ifdef FUNC_SWEEP_ERRLOG_EN
  assign err_valid     = errv_q;
  assign first_err_idx = eidx_q;
`endif

endmodule

// File: tb/tb_func_sweep_checker.sv
// Scoreboard bench for func_sweep_checker: two instances (SETTLE_CYCLES=2 and 1) driven by a model f.
module tb_func_sweep_checker;

  typedef struct packed {
    logic [15:0] tbl;
    logic        pss;
    logic        ev;
    logic [3:0]  eidx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int mode  = 0;
  logic [15:0] model_tt = 16'h87B6;

  logic start0 = 1'b0, start1 = 1'b0;
  logic f0, f1, a0, b0, c0, d0, a1, b1, c1, d1;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] tt0, tt1;
  logic [3:0] code0, code1;
  logic ev0, ev1;
  logic [3:0] ei0, ei1;

  exp_t q0[$];
  exp_t q1[$];

  assign code0 = {a0, b0, c0, d0};
  assign code1 = {a1, b1, c1, d1};

  // Function block model: 0 = correct, 1 = stuck at 0, 2 = correct except f(3)=1.
  always_comb begin
    f0 = model_tt[code0];
    if (mode == 1) f0 = 1'b0;
    else if (mode == 2 && code0 == 4'd3) f0 = 1'b1;
  end
  always_comb f1 = model_tt[code1];

  func_sweep_checker #(.SETTLE_CYCLES(2), .EXPECT_TT(16'h87B6)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .f_in(f0),
    .a(a0), .b(b0), .c(c0), .d(d0),
    .busy(busy0), .done(done0), .truth_tbl(tt0), .pass(pass0)
`ifdef FUNC_SWEEP_ERRLOG_EN
    , .err_valid(ev0), .first_err_idx(ei0)
`endif
  );

  func_sweep_checker #(.SETTLE_CYCLES(1), .EXPECT_TT(16'h87B6)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f_in(f1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .busy(busy1), .done(done1), .truth_tbl(tt1), .pass(pass1)
`ifdef FUNC_SWEEP_ERRLOG_EN
    , .err_valid(ev1), .first_err_idx(ei1)
`endif
  );

`ifndef FUNC_SWEEP_ERRLOG_EN
  assign ev0 = 1'b0;
  assign ei0 = 4'd0;
  assign ev1 = 1'b0;
  assign ei1 = 4'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag, input exp_t e, input logic [15:0] tt,
                              input logic p, input logic ev, input logic [3:0] ei);
    chk({tag, "_truth_tbl"}, {16'd0, tt}, {16'd0, e.tbl});
    chk({tag, "_pass"}, {31'd0, p}, {31'd0, e.pss});
`ifdef FUNC_SWEEP_ERRLOG_EN
    chk({tag, "_err_valid"}, {31'd0, ev}, {31'd0, e.ev});
    chk({tag, "_first_err_idx"}, {28'd0, ei}, {28'd0, e.eidx});
`endif
  endtask

  // Monitors: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst && done0) begin
      if (q0.size() == 0) chk("dut0_unexpected_done", 32'd1, 32'd0);
      else check_result("dut0", q0.pop_front(), tt0, pass0, ev0, ei0);
    end
    if (!rst && done1) begin
      if (q1.size() == 0) chk("dut1_unexpected_done", 32'd1, 32'd0);
      else check_result("dut1", q1.pop_front(), tt1, pass1, ev1, ei1);
    end
  end

  // Full sweep on dut0; poke=1 also pulses start at the 10th busy cycle and in DONE.
  task automatic sweep0(input logic [15:0] etbl, input logic epass, input logic ev,
                        input logic [3:0] eidx, input bit poke);
    exp_t e;
    int k, bad, extra;
    e.tbl = etbl; e.pss = epass; e.ev = ev; e.eidx = eidx;
    @(negedge clk);
    start0 = 1'b1;
    q0.push_back(e);
    @(posedge clk);
    #1 start0 = 1'b0;
    k = 0; bad = 0;
    while (1) begin
      @(negedge clk);
      if (done0) break;
      if (!busy0) bad++;
      if (poke && k == 9) start0 = 1'b1;
      if (k >= 200) break;
      @(posedge clk);
      #1 start0 = 1'b0;
      k++;
    end
    chk("done_latency", k, 48);
    chk("busy_held", bad, 0);
    chk("busy_low_in_done", {31'd0, busy0}, 32'd0);
    if (poke) begin
      start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
      extra = 0;
      repeat (60) begin
        @(negedge clk);
        if (done0 || busy0) extra++;
      end
      chk("no_restart", extra, 0);
    end
  endtask

  initial begin
    int k, bad, extra;
    exp_t e;
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k, bad, extra;
    exp_t e;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy0, done0, pass0, code0, tt0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy0, done0, code0, tt0}, 32'd0);

    // Correct block, stuck-at-0 block, single-code fault.
    mode = 0; sweep0(16'h87B6, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("hold_code15", {28'd0, code0}, 32'd15);
    mode = 1; sweep0(16'h0000, 1'b0, 1'b1, 4'd1, 1'b0);
    mode = 2; sweep0(16'h87BE, 1'b0, 1'b1, 4'd3, 1'b0);
    // Restarts while busy and in DONE are ignored.
    mode = 0; sweep0(16'h87B6, 1'b1, 1'b0, 4'd0, 1'b1);

    // Asynchronous reset at code 7 aborts without a done pulse.
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    k = 0;
    while (code0 != 4'd7 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reached_code7", {28'd0, code0}, 32'd7);
    #2 rst = 1'b1;
    #1 chk("async_reset_clear", {busy0, done0, pass0, code0, tt0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (done0 || busy0) extra++;
    end
    chk("no_done_after_abort", extra, 0);
    sweep0(16'h87B6, 1'b1, 1'b0, 4'd0, 1'b0);

    // SETTLE_CYCLES=1: code advances every 2 cycles, done after 32 edges.
    e.tbl = 16'h87B6; e.pss = 1'b1; e.ev = 1'b0; e.eidx = 4'd0;
    @(negedge clk);
    start1 = 1'b1;
    q1.push_back(e);
    @(posedge clk);
    #1 start1 = 1'b0;
    k = 0; bad = 0;
    while (1) begin
      @(negedge clk);
      if (done1) break;
      if (code1 != 4'(k >> 1)) bad++;
      if (!busy1) bad++;
      if (k >= 100) break;
      @(posedge clk);
      #1 k++;
    end
    chk("s1_done_latency", k, 32);
    chk("s1_code_step", bad, 0);
    chk("s1_code_hold", {28'd0, code1}, 32'd15);

    repeat (3) @(negedge clk);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
